fb_write_arbiter: RTL and testbench

//  Shares the single framebuffer RAM write port between NUM_REQ pixel producers (map, sprite, fade/overlay passes).

---
 rtl/fb_arb_pkg.sv | 15 +
 rtl/fb_rr_picker.sv | 27 ++
 rtl/fb_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizes for the framebuffer write arbiter.
// Optional build macro FB_ARB_FIXED_PRIO_EN (see fb_write_arbiter) needs nothing from here.
package fb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int FB_ADDR_W    = 19;
    localparam int FB_DATA_W    = 24;
    localparam int FB_NUM_REQ   = 3;
    localparam int FB_MAX_BURST = 16;

endpackage

// File: rtl/fb_rr_picker.sv
// Combinational rotating-priority picker: first valid requester at or after rr_ptr, wrapping.
// With rr_ptr tied to zero it degenerates to lowest-index priority.
module fb_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    int idx_s;

    // Scan from the farthest slot back to rr_ptr so the closest valid one is written last.
    always_comb begin
        any    = |valid;
        winner = {ID_W{1'b0}};
        idx_s  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s  = int'(rr_ptr) + k;
            idx_s  = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
            winner = valid[idx_s] ? ID_W'(idx_s) : winner;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Burst arbiter sharing the framebuffer RAM write port among pixel producers during the write window.
// Define FB_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ   = FB_NUM_REQ,
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int MAX_BURST = FB_MAX_BURST
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         win_open,
    input  logic                         frame_start,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fb_we,
    output logic [ADDR_W-1:0]            fb_addr,
    output logic [DATA_W-1:0]            fb_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         burst_abort
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    arb_state_t          state_r;
    logic [ID_W-1:0]     owner_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic                fb_we_r;
    logic [ADDR_W-1:0]   fb_addr_r;
    logic [DATA_W-1:0]   fb_data_r;
    logic [ID_W-1:0]     grant_id_r;
    logic                burst_abort_r;

    logic [ID_W-1:0]     pick_ptr_s;
    logic                pick_any_s;
    logic [ID_W-1:0]     pick_id_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic [ID_W-1:0]     hs_id_s;
    logic                hs_s;
    logic                hs_last_s;
    logic                cnt_full_s;

    // Pointer value after a burst by this owner ends; fixed priority keeps it at zero.
    function automatic logic [ID_W-1:0] rr_after(input logic [ID_W-1:0] id);
`ifdef FB_ARB_FIXED_PRIO_EN
        return {ID_W{1'b0}};
`else
        return (id == LAST_ID) ? {ID_W{1'b0}} : (id + ID_W'(1));
`endif
    endfunction

`ifdef FB_ARB_FIXED_PRIO_EN
    assign pick_ptr_s = {ID_W{1'b0}};
`else
    assign pick_ptr_s = rr_ptr_r;
`endif

    fb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid   (req_valid),
        .rr_ptr  (pick_ptr_s),
        .any     (pick_any_s),
        .winner  (pick_id_s)
    );

    // Ready generation: frame_start blanks everything, otherwise only the candidate/owner may see ready.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        hs_id_s = (state_r == ARB_IDLE) ? pick_id_s : owner_r;
        if (frame_start) begin
            ready_s = {NUM_REQ{1'b0}};
        end else if (state_r == ARB_IDLE) begin
            ready_s[pick_id_s] = win_open & pick_any_s;
        end else begin
            ready_s[owner_r] = win_open;
        end
    end

    assign hs_s       = |(ready_s & req_valid);
    assign hs_last_s  = req_last[hs_id_s];
    assign cnt_full_s = ((beat_cnt_r + CNT_W'(1)) == MAX_CNT);

    // Arbitration state, burst bookkeeping and the registered write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= ARB_IDLE;
            owner_r       <= {ID_W{1'b0}};
            rr_ptr_r      <= {ID_W{1'b0}};
            beat_cnt_r    <= {CNT_W{1'b0}};
            fb_we_r       <= 1'b0;
            fb_addr_r     <= {ADDR_W{1'b0}};
            fb_data_r     <= {DATA_W{1'b0}};
            grant_id_r    <= {ID_W{1'b0}};
            burst_abort_r <= 1'b0;
        end else begin
            fb_we_r       <= hs_s;
            burst_abort_r <= frame_start & (state_r == ARB_BURST);
            if (hs_s) begin
                fb_addr_r  <= req_addr[int'(hs_id_s) * ADDR_W +: ADDR_W];
                fb_data_r  <= req_data[int'(hs_id_s) * DATA_W +: DATA_W];
                grant_id_r <= hs_id_s;
            end
            if (frame_start) begin
                state_r    <= ARB_IDLE;
                rr_ptr_r   <= {ID_W{1'b0}};
                beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ARB_IDLE: begin
                        if (hs_s) begin
                            owner_r <= pick_id_s;
                            // A single-beat grant ends immediately; the counter is cleared, never left at 1.
                            if (hs_last_s || (MAX_BURST == 1)) begin
                                rr_ptr_r   <= rr_after(pick_id_s);
                                beat_cnt_r <= {CNT_W{1'b0}};
                            end else begin
                                state_r    <= ARB_BURST;
                                beat_cnt_r <= CNT_W'(1);
                            end
                        end
                    end
                    ARB_BURST: begin
                        if (hs_s) begin
                            if (hs_last_s || cnt_full_s) begin
                                state_r    <= ARB_IDLE;
                                rr_ptr_r   <= rr_after(owner_r);
                                beat_cnt_r <= {CNT_W{1'b0}};
                            end else begin
                                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r    <= ARB_IDLE;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign req_ready   = ready_s;
    assign fb_we       = fb_we_r;
    assign fb_addr     = fb_addr_r;
    assign fb_data     = fb_data_r;
    assign grant_id    = grant_id_r;
    assign busy        = (state_r == ARB_BURST);
    assign burst_abort = burst_abort_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: directed producer streams, hand-ordered expected write sequence.
module tb_fb_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 19;
    localparam int DW = 24;
    localparam int IW = 2;
    localparam int EW = IW + AW + DW;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              win_open;
    logic              frame_start;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [DW-1:0]     fb_data;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              burst_abort;

    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t           src_q[NR][$];
    logic [EW-1:0]   exp_q[$];
    logic [NR-1:0]   hs_r;
    int pass_cnt = 0;
    int chk_cnt  = 0;
    int hs_total = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int first_we = -1;
    int last_we  = -1;
    int abort_cnt = 0;

    fb_write_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .win_open    (win_open),
        .frame_start (frame_start),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_abort (burst_abort)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] b_addr(input int r, input int i);
        return AW'(r * 4096 + i);
    endfunction

    function automatic logic [DW-1:0] b_data(input int r, input int i);
        return DW'(32'h00A50000 + r * 256 + i);
    endfunction

    // Queue n beats for requester r; last flag optionally on the final one.
    task automatic load(input int r, input int first, input int n, input bit last_end);
        beat_t b;
        for (int i = first; i < first + n; i++) begin
            b.last = last_end && (i == first + n - 1);
            b.addr = b_addr(r, i);
            b.data = b_data(r, i);
            src_q[r].push_back(b);
        end
    endtask

    task automatic expect_beats(input int r, input int first, input int n);
        for (int i = first; i < first + n; i++)
            exp_q.push_back({IW'(r), b_addr(r, i), b_data(r, i)});
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_hs(input string name, input int target);
        int n = 0;
        while (hs_total < target && n < 300) begin
            tick();
            n++;
        end
        if (hs_total < target) check(name, 64'(hs_total), 64'(target));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    // Producer model: pop accepted beats, present the next head, sample handshakes just before the edge.
    initial begin
        beat_t b;
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        hs_r      = '0;
        forever begin
            @(negedge Clk);
            for (int i = 0; i < NR; i++)
                if (hs_r[i] && src_q[i].size() > 0) src_q[i].delete(0);
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_last[i]  = b.last;
                    req_addr[i*AW +: AW] = b.addr;
                    req_data[i*DW +: DW] = b.data;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #4;
            hs_r = req_valid & req_ready;
            hs_total += $countones(hs_r);
        end
    end

    // Monitor: every framebuffer write must match the head of the expected queue.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (burst_abort === 1'b1) abort_cnt++;
            if (fb_we === 1'b1) begin
                we_cnt++;
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL spurious_we: got id=%0d addr=0x%0h data=0x%0h expected no write",
                             grant_id, fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'({grant_id, fb_addr, fb_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        int base;
        int snap;
        bit busy_seen;
        Reset = 1'b1;
        win_open = 1'b0;
        frame_start = 1'b0;
        repeat (3) tick();
        check("rst_fb_we", 64'(fb_we), 64'd0);
        check("rst_fb_addr", 64'(fb_addr), 64'd0);
        check("rst_fb_data", 64'(fb_data), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_abort", 64'(burst_abort), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        Reset = 1'b0;
        tick();

        // 1: single req0 beat, never enters BURST
        src_q[0].push_back({1'b1, 19'h00010, 24'hE8E088});
        exp_q.push_back({2'd0, 19'h00010, 24'hE8E088});
        win_open = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_seen |= busy;
        end
        check("t1_busy", 64'(busy_seen), 64'd0);
        drain("t1_drain");
        // rr_ptr now 1: req1 beats req0 on a tie, then req0
        load(1, 0, 1, 1'b1);
        load(0, 1, 1, 1'b1);
        expect_beats(1, 0, 1);
        expect_beats(0, 1, 1);
        drain("t1_rr");

        // frame_start while idle: pointer back to 0, no abort
        snap = abort_cnt;
        win_open = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        check("idle_fs_abort", 64'(abort_cnt - snap), 64'd0);

        // 2: three requesters, bursts of 4, order 0,1,2,0 with no gaps
        load(0, 0, 4, 1'b1);
        load(0, 4, 4, 1'b1);
        load(1, 0, 4, 1'b1);
        load(2, 0, 4, 1'b1);
        expect_beats(0, 0, 4);
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 4);
        expect_beats(0, 4, 4);
        tick();
        first_we = -1;
        win_open = 1'b1;
        drain("t2_drain");
        check("t2_gapless", 64'(last_we - first_we + 1), 64'd16);

        // 3: req1 streams 40 beats, forced rotation at 16
        win_open = 1'b0;
        load(1, 0, 40, 1'b1);
        load(2, 0, 16, 1'b0);
        expect_beats(1, 0, 16);
        expect_beats(2, 0, 16);
        expect_beats(1, 16, 24);
        tick();
        first_we = -1;
        win_open = 1'b1;
        drain("t3_drain");
        check("t3_gapless", 64'(last_we - first_we + 1), 64'd56);

        // 4: window closes after beat 3 of req0; req1 waiting must not steal the grant
        win_open = 1'b0;
        load(0, 0, 6, 1'b1);
        load(1, 0, 1, 1'b1);
        expect_beats(0, 0, 6);
        expect_beats(1, 0, 1);
        tick();
        base = hs_total;
        win_open = 1'b1;
        wait_hs("t4_hs_timeout", base + 3);
        win_open = 1'b0;
        snap = we_cnt;
        repeat (10) tick();
        check("t4_gap_we", 64'(we_cnt - snap), 64'd0);
        check("t4_busy_held", 64'(busy), 64'd1);
        check("t4_grant_held", 64'(grant_id), 64'd0);
        win_open = 1'b1;
        drain("t4_drain");

        // 5: frame_start during beat 5 of a req2 burst
        win_open = 1'b0;
        load(2, 0, 8, 1'b1);
        load(0, 0, 1, 1'b1);
        expect_beats(2, 0, 4);
        expect_beats(0, 0, 1);
        expect_beats(2, 4, 4);
        tick();
        snap = abort_cnt;
        base = hs_total;
        win_open = 1'b1;
        wait_hs("t5_hs_timeout", base + 4);
        frame_start = 1'b1;
        #1;
        check("t5_ready_blank", 64'(req_ready), 64'd0);
        tick();
        frame_start = 1'b0;
        check("t5_abort_pulse", 64'(burst_abort), 64'd1);
        check("t5_no_hs", 64'(hs_total - base), 64'd4);
        drain("t5_drain");
        check("t5_abort_cnt", 64'(abort_cnt - snap), 64'd1);

        // 6: reset mid-burst, then a tie goes to req0
        load(0, 0, 10, 1'b1);
        expect_beats(0, 0, 3);
        base = hs_total;
        wait_hs("t6_hs_timeout", base + 3);
        Reset = 1'b1;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        tick();
        check("t6_fb_we", 64'(fb_we), 64'd0);
        check("t6_fb_addr", 64'(fb_addr), 64'd0);
        check("t6_fb_data", 64'(fb_data), 64'd0);
        check("t6_grant_id", 64'(grant_id), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_abort", 64'(burst_abort), 64'd0);
        check("t6_exp_empty", 64'(exp_q.size()), 64'd0);
        tick();
        Reset = 1'b0;
        tick();
        load(2, 0, 1, 1'b1);
        load(0, 0, 1, 1'b1);
        expect_beats(0, 0, 1);
        expect_beats(2, 0, 1);
        drain("t6_tie");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
